// File: rtl/carbon_csr_responder_simple.sv
// Carbon CSR responder: 32-byte register window with a fixed-latency response path.
// Optional privilege gating is enabled by defining CARBON_CSR_RESP_PRIV_CHECK_EN.
module carbon_csr_responder_simple #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE     = 32'hCA5B_0001,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [1:0]  MIN_PRIV     = 2'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [1:0]  req_priv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] ctrl_q,
    output logic [7:0]  mode_q,
    output logic [31:0] modeflags_q,
    input  logic [3:0]  status_set,
    output logic [3:0]  status_q
);

    localparam logic [2:0] LAT = 3'(RESP_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [31:0] ctrl_d;
    logic [7:0]  mode_d;
    logic [31:0] modeflags_d;
    logic [3:0]  status_d;
    logic [31:0] scratch_q, scratch_d;

    logic [31:0] off;
    logic [2:0]  idx;
    logic        in_range;
    logic        priv_bad;
    logic        bad;
    logic        accept;
    logic        wr_ok;
    logic [3:0]  w1c;
    logic [31:0] rd_mux;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  ws
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

`ifdef CARBON_CSR_RESP_PRIV_CHECK_EN
    assign priv_bad = (req_priv < MIN_PRIV);
`else
    logic unused_priv;
    assign unused_priv = ^{req_priv, MIN_PRIV};
    assign priv_bad    = 1'b0;
`endif

    assign off      = req_addr - BASE_ADDR;
    assign idx      = off[4:2];
    assign in_range = (req_addr >= BASE_ADDR) && (off < 32'd32);

    // idx 6 and 7 are the unmapped tail of the window
    assign bad = !in_range
              || (req_addr[1:0] != 2'b00)
              || (idx > 3'd5)
              || (req_write && (idx == 3'd0))
              || priv_bad;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign wr_ok     = accept && req_write && !bad;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

    assign w1c = (wr_ok && (idx == 3'd3) && req_wstrb[0])
               ? req_wdata[3:0] : 4'h0;

    always_comb begin
        rd_mux = 32'h0;
        case (idx)
            3'd0:    rd_mux = ID_VALUE;
            3'd1:    rd_mux = ctrl_q;
            3'd2:    rd_mux = {24'h0, mode_q};
            3'd3:    rd_mux = {28'h0, status_q};
            3'd4:    rd_mux = scratch_q;
            3'd5:    rd_mux = modeflags_q;
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fault_d = bad;
                    rdata_d = (bad || req_write) ? 32'h0 : rd_mux;
                    if (LAT == 3'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        mode_d      = mode_q;
        modeflags_d = modeflags_q;
        scratch_d   = scratch_q;
        // a same-cycle set overrides a W1C on the same bit
        status_d    = (status_q & ~w1c) | status_set;
        if (wr_ok) begin
            case (idx)
                3'd1: ctrl_d = merge(ctrl_q, req_wdata, req_wstrb);
                3'd2: if (req_wstrb[0]) mode_d = req_wdata[7:0];
                3'd4: scratch_d = merge(scratch_q, req_wdata, req_wstrb);
                3'd5: modeflags_d = merge(modeflags_q, req_wdata, req_wstrb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            ctrl_q      <= 32'h0;
            mode_q      <= 8'h0;
            modeflags_q <= 32'h0000_0001;
            status_q    <= 4'h0;
            scratch_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            ctrl_q      <= ctrl_d;
            mode_q      <= mode_d;
            modeflags_q <= modeflags_d;
            status_q    <= status_d;
            scratch_q   <= scratch_d;
        end
    end

endmodule

// File: tb/tb_carbon_csr_responder_simple.sv
// Directed bench for carbon_csr_responder_simple.
// Instances run at latencies 1 (default), 0 and 7.
module tb_carbon_csr_responder_simple;

    localparam logic [31:0] IDV = 32'hCA5B_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  req_priv;
    logic [2:0]  rvl;
    logic        rsp_ready;
    logic [31:0] rdt [3];
    logic [2:0]  rft;
    logic [31:0] ctl [3];
    logic [7:0]  mod [3];
    logic [31:0] mf  [3];
    logic [3:0]  status_set;
    logic [3:0]  st  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carbon_csr_responder_simple u_d0 (
        .clk(clk), .rst(rst),
        .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_priv(req_priv),
        .rsp_valid(rvl[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdt[0]), .rsp_fault(rft[0]),
        .ctrl_q(ctl[0]), .mode_q(mod[0]), .modeflags_q(mf[0]),
        .status_set(status_set), .status_q(st[0])
    );

    carbon_csr_responder_simple #(.RESP_LATENCY(0)) u_d1 (
        .clk(clk), .rst(rst),
        .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_priv(req_priv),
        .rsp_valid(rvl[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdt[1]), .rsp_fault(rft[1]),
        .ctrl_q(ctl[1]), .mode_q(mod[1]), .modeflags_q(mf[1]),
        .status_set(status_set), .status_q(st[1])
    );

    carbon_csr_responder_simple #(.RESP_LATENCY(7)) u_d2 (
        .clk(clk), .rst(rst),
        .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_priv(req_priv),
        .rsp_valid(rvl[2]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdt[2]), .rsp_fault(rft[2]),
        .ctrl_q(ctl[2]), .mode_q(mod[2]), .modeflags_q(mf[2]),
        .status_set(status_set), .status_q(st[2])
    );

    // lat = 0 means no response within the budget
    task automatic do_txn(
        input  int          k,
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [3:0]  ws,
        input  logic [1:0]  pv,
        input  logic [3:0]  ss,
        output logic [31:0] rd,
        output logic        f,
        output int          lat,
        output logic        acc
    );
        @(negedge clk);
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_wstrb  = ws;
        req_priv   = pv;
        status_set = ss;
        rsp_ready  = 1'b1;
        vld[k]     = 1'b1;
        #1 acc = rdy[k];
        @(posedge clk);
        #1;
        vld[k]     = 1'b0;
        req_write  = 1'b0;
        status_set = 4'h0;
        lat = 0;
        rd  = 32'h0;
        f   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rvl[k]) begin
                lat = i;
                rd  = rdt[k];
                f   = rft[k];
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vld = 3'b000;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        req_priv = 2'd3;
        rsp_ready = 1'b1;
        status_set = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_in_reset got %b want 0", rdy[0]);
        end
        rst = 1'b0;
        status_set = 4'h0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_after got %b want 1", rdy[0]);
        end
        checks++;
        if ({rvl[0], rft[0], rdt[0]} !== 34'h0) begin
            errors++;
            $display("FAIL rst_rsp got v%b f%b d%h want 0", rvl[0], rft[0], rdt[0]);
        end
        checks++;
        if (ctl[0] !== 32'h0 || mod[0] !== 8'h0) begin
            errors++;
            $display("FAIL rst_ctrl_mode got %h %h want 0 0", ctl[0], mod[0]);
        end
        checks++;
        if (mf[0] !== 32'h1 || st[0] !== 4'h0) begin
            errors++;
            $display("FAIL rst_mf_status got %h %h want 1 0", mf[0], st[0]);
        end
    endtask

    task automatic test_modeflags;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        do_txn(0, 1'b1, 32'h14, 32'h0, 4'hF, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (acc !== 1'b1 || lat != 2 || f !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL mf_write got acc%b lat%0d f%b d%h want 1 2 0 0", acc, lat, f, rd);
        end
        checks++;
        if (mf[0] !== 32'h0) begin
            errors++;
            $display("FAIL mf_out got %h want 0", mf[0]);
        end
        do_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (lat != 2 || f !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL mf_read got lat%0d f%b d%h want 2 0 0", lat, f, rd);
        end
    endtask

    task automatic test_ctrl_wstrb;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        do_txn(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, 2'd3, 4'h0, rd, f, lat, acc);
        do_txn(0, 1'b0, 32'h04, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (rd !== 32'h00BB00DD || f !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_read got %h f%b want 00bb00dd 0", rd, f);
        end
        checks++;
        if (ctl[0] !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL ctrl_out got %h want 00bb00dd", ctl[0]);
        end
        do_txn(0, 1'b1, 32'h08, 32'hFFFF_FF5A, 4'hF, 2'd3, 4'h0, rd, f, lat, acc);
        do_txn(0, 1'b0, 32'h08, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (rd !== 32'h0000_005A || mod[0] !== 8'h5A) begin
            errors++;
            $display("FAIL mode_rw got %h %h want 0000005a 5a", rd, mod[0]);
        end
        do_txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (rd !== IDV || f !== 1'b0) begin
            errors++;
            $display("FAIL id_read got %h f%b want %h 0", rd, f, IDV);
        end
    endtask

    task automatic test_status;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        @(negedge clk);
        status_set = 4'b1010;
        @(negedge clk);
        status_set = 4'h0;
        checks++;
        if (st[0] !== 4'hA) begin
            errors++;
            $display("FAIL status_set got %h want a", st[0]);
        end
        do_txn(0, 1'b0, 32'h0C, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (rd !== 32'hA) begin
            errors++;
            $display("FAIL status_read got %h want a", rd);
        end
        do_txn(0, 1'b1, 32'h0C, 32'hF, 4'h1, 2'd3, 4'b0010, rd, f, lat, acc);
        checks++;
        if (st[0] !== 4'h2 || f !== 1'b0) begin
            errors++;
            $display("FAIL status_w1c_race got %h f%b want 2 0", st[0], f);
        end
        do_txn(0, 1'b1, 32'h0C, 32'hF, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (st[0] !== 4'h2 || f !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL status_wstrb0 got %h f%b d%h want 2 0 0", st[0], f, rd);
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        logic [31:0] addrs [4];
        addrs = '{32'h18, 32'h1C, 32'h06, 32'h20};
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b0, addrs[i], 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
            checks++;
            if (f !== 1'b1 || rd !== 32'h0 || lat != 2) begin
                errors++;
                $display("FAIL fault_read a%h got f%b d%h lat%0d want 1 0 2", addrs[i], f, rd, lat);
            end
        end
        do_txn(0, 1'b1, 32'h00, 32'h1234, 4'hF, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (f !== 1'b1) begin
            errors++;
            $display("FAIL fault_id_write got f%b want 1", f);
        end
        do_txn(0, 1'b0, 32'h00, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (rd !== IDV || f !== 1'b0) begin
            errors++;
            $display("FAIL id_after_write got %h want %h", rd, IDV);
        end
        do_txn(0, 1'b1, 32'h05, 32'hFFFF_FFFF, 4'hF, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (f !== 1'b1 || ctl[0] !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL fault_misaligned got f%b ctrl%h want 1 00bb00dd", f, ctl[0]);
        end
    endtask

    task automatic test_stall;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        bit seen;
        do_txn(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 2'd3, 4'h0, rd, f, lat, acc);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h10;
        vld[0]    = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rvl[0];
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_no_rsp got 0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rvl[0] !== 1'b1 || rdt[0] !== 32'h1234_5678 ||
                rft[0] !== 1'b0 || rdy[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d got v%b d%h f%b r%b want 1 12345678 0 0",
                         i, rvl[0], rdt[0], rft[0], rdy[0]);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rvl[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got v%b r%b want 0 1", rvl[0], rdy[0]);
        end
    endtask

    task automatic test_latency;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        do_txn(1, 1'b0, 32'h00, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (lat != 1 || rd !== IDV) begin
            errors++;
            $display("FAIL lat0 got lat%0d d%h want 1 %h", lat, rd, IDV);
        end
        do_txn(2, 1'b0, 32'h00, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
        checks++;
        if (lat != 8 || rd !== IDV) begin
            errors++;
            $display("FAIL lat7 got lat%0d d%h want 8 %h", lat, rd, IDV);
        end
    endtask

    task automatic test_reset_wait;
        int hits;
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 32'h00;
        vld[2]    = 1'b1;
        @(posedge clk);
        #1 vld[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL rw_ready_in_reset got %b want 0", rdy[2]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy[2] !== 1'b1 || rvl[2] !== 1'b0) begin
            errors++;
            $display("FAIL rw_after got r%b v%b want 1 0", rdy[2], rvl[2]);
        end
        checks++;
        if (ctl[0] !== 32'h0 || mod[0] !== 8'h0 || mf[0] !== 32'h1 || st[0] !== 4'h0) begin
            errors++;
            $display("FAIL rw_regs got %h %h %h %h want 0 0 1 0", ctl[0], mod[0], mf[0], st[0]);
        end
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvl[2]) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL rw_dropped got %0d responses want 0", hits);
        end
    endtask

    task automatic test_priv;
        logic [31:0] rd;
        logic f, acc;
        int lat;
        do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'd0, 4'h0, rd, f, lat, acc);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 2'd3, 4'h0, rd, f, lat, acc);
`ifdef CARBON_CSR_RESP_PRIV_CHECK_EN
        checks++;
        if (f !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL priv_scratch got f%b d%h want 0 0", f, rd);
        end
`else
        checks++;
        if (f !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL priv_scratch got f%b d%h want 0 deadbeef", f, rd);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_modeflags();
        test_ctrl_wstrb();
        test_status();
        test_faults();
        test_stall();
        test_latency();
        test_reset_wait();
        test_priv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
